// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter that multiplexes NUM_MASTERS request ports onto one SRAM port
// and routes each response back through a one-entry skid buffer per master.
module sram_rr_arbiter #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int NUM_WORDS   = 1024,
  parameter  int NUM_MASTERS = 2,
  localparam int AW          = $clog2(NUM_WORDS),
  localparam int MW          = $clog2(NUM_MASTERS),
  localparam int BW          = DATA_WIDTH / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_MASTERS-1:0]      req_i,
  input  logic [NUM_MASTERS-1:0]      we_i,
  input  logic [NUM_MASTERS*AW-1:0]   addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_MASTERS*BW-1:0]   be_i,
  output logic [NUM_MASTERS-1:0]      gnt_o,
  output logic [NUM_MASTERS-1:0]      rvalid_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] rdata_o,
  input  logic [NUM_MASTERS-1:0]      rready_i,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [AW-1:0]               sram_addr_o,
  output logic [DATA_WIDTH-1:0]       sram_wdata_o,
  output logic [BW-1:0]               sram_be_o,
  input  logic [DATA_WIDTH-1:0]       sram_rdata_i
);

  localparam logic [MW:0]   NM_W = (MW+1)'(NUM_MASTERS);
  localparam logic [MW-1:0] LAST = MW'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] pend_q;
  logic [NUM_MASTERS-1:0] hold_valid_q;
  logic [NUM_MASTERS-1:0] we_q;
  logic [DATA_WIDTH-1:0]  hold_data_q [NUM_MASTERS];
  logic [MW-1:0]          ptr_q;

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] gnt;
  logic [MW-1:0]          gnt_idx;
  logic [MW:0]            cand_idx;
  logic                   found;
  logic [DATA_WIDTH-1:0]  resp_data [NUM_MASTERS];

  // A pending response being consumed this cycle frees the master for a new grant.
  assign elig = ~hold_valid_q & (~pend_q | rready_i);

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_idx = {1'b0, ptr_q} + (MW+1)'(i);
      if (cand_idx >= NM_W) cand_idx = cand_idx - NM_W;
      if (!found && !rst_i && req_i[cand_idx[MW-1:0]] && elig[cand_idx[MW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand_idx[MW-1:0];
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  assign gnt_o      = gnt;
  assign sram_req_o = found;

  always_comb begin
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (gnt[m]) begin
        sram_we_o    = we_i[m];
        sram_addr_o  = addr_i[m*AW +: AW];
        sram_wdata_o = wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
        sram_be_o    = be_i[m*BW +: BW];
      end
    end
  end

  // Response stage: the held entry takes priority over the live SRAM beat.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      resp_data[m] = we_q[m] ? '0 : sram_rdata_i;
      if (!rst_i) begin
        if (hold_valid_q[m]) begin
          rvalid_o[m] = 1'b1;
          rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = hold_data_q[m];
        end else if (pend_q[m]) begin
          rvalid_o[m] = 1'b1;
          rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = resp_data[m];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q       <= '0;
      hold_valid_q <= '0;
      we_q         <= '0;
      ptr_q        <= '0;
      for (int m = 0; m < NUM_MASTERS; m++) hold_data_q[m] <= '0;
    end else begin
      pend_q <= gnt;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (gnt[m]) we_q[m] <= we_i[m];
        if (hold_valid_q[m]) begin
          if (rready_i[m]) hold_valid_q[m] <= 1'b0;
        end else if (pend_q[m] && !rready_i[m]) begin
          hold_valid_q[m] <= 1'b1;
          hold_data_q[m]  <= resp_data[m];
        end
      end
      if (found) ptr_q <= (gnt_idx == LAST) ? '0 : gnt_idx + MW'(1);
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed vector table, hand sequences and random traffic
// against a transaction-level model with a behavioural SRAM.
module tb_sram_rr_arbiter;
  localparam int DW = 32;
  localparam int NW = 1024;
  localparam int NM = 2;
  localparam int AW = 10;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    req, we, rready, gnt, rvalid;
  logic [NM*AW-1:0] addr;
  logic [NM*DW-1:0] wdata, rdata;
  logic [NM*BW-1:0] be;
  logic             sram_req, sram_we;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata, sram_rdata;
  logic [BW-1:0]    sram_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_MASTERS(NM)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .rready_i(rready), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata)
  );

  function automatic logic [DW-1:0] init_word(int a);
    return 32'(a) * 32'h11;
  endfunction

  // Behavioural single-port SRAM; contents are preloaded on the first clock edge.
  logic [DW-1:0] sram_mem [NW];
  bit init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= init_word(i);
      init_done  <= 1'b1;
      sram_rdata <= 32'hA5A5_A5A5;
    end else if (sram_req && !sram_we) begin
      sram_rdata <= sram_mem[sram_addr];
    end else begin
      sram_rdata <= 32'hA5A5_A5A5;
      if (sram_req)
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
  end

  // Transaction-level model: one response slot per master, filled at grant time.
  bit [DW-1:0] mdl_mem [NW];
  bit          slot_v [NM];
  bit          slot_fresh [NM];
  bit [DW-1:0] slot_d [NM];
  int          rr_next;
  logic [NM-1:0] last_gnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic settle_check();
    logic [NM-1:0] eg, erv;
    logic [NM*DW-1:0] erd;
    logic ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [BW-1:0] ebe;
    int g;
    #2;
    eg = '0; erv = '0; erd = '0; ewe = 1'b0; ea = '0; ewd = '0; ebe = '0; g = -1;
    if (!rst) begin
      for (int k = 0; k < NM; k++) begin
        int m = (rr_next + k) % NM;
        if (g < 0 && req[m] && (!slot_v[m] || (slot_fresh[m] && rready[m]))) g = m;
      end
      if (g >= 0) begin
        eg[g] = 1'b1;
        ewe   = we[g];
        ea    = addr[g*AW +: AW];
        ewd   = wdata[g*DW +: DW];
        ebe   = be[g*BW +: BW];
      end
      for (int m = 0; m < NM; m++) begin
        erv[m] = slot_v[m];
        if (slot_v[m]) erd[m*DW +: DW] = slot_d[m];
      end
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("sram_req", 64'(sram_req), 64'(|eg));
    chk("sram_we", 64'(sram_we), 64'(ewe));
    chk("sram_addr", 64'(sram_addr), 64'(ea));
    chk("sram_wdata", 64'(sram_wdata), 64'(ewd));
    chk("sram_be", 64'(sram_be), 64'(ebe));
    chk("rvalid", 64'(rvalid), 64'(erv));
    chk("rdata", 64'(rdata), 64'(erd));
    if (rst) begin
      for (int m = 0; m < NM; m++) begin slot_v[m] = 0; slot_fresh[m] = 0; end
      rr_next = 0;
    end else begin
      for (int m = 0; m < NM; m++) begin
        if (slot_v[m] && rready[m]) slot_v[m] = 0;
        slot_fresh[m] = 0;
      end
      if (g >= 0) begin
        slot_v[g] = 1; slot_fresh[g] = 1;
        if (ewe) begin
          for (int b = 0; b < BW; b++) if (ebe[b]) mdl_mem[ea][b*8 +: 8] = ewd[b*8 +: 8];
          slot_d[g] = '0;
        end else begin
          slot_d[g] = mdl_mem[ea];
        end
        rr_next = (g + 1) % NM;
      end
    end
    last_gnt = eg;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input bit [1:0] rq, w, rd, input bit [9:0] a0, a1,
                        input bit [31:0] d0, d1, input bit [3:0] b0, b1);
    rst = r; req = rq; we = w; rready = rd;
    addr = {a1, a0}; wdata = {d1, d0}; be = {b1, b0};
  endtask

  typedef struct {
    bit rst; bit [1:0] req, we, rdy; bit [9:0] a0, a1; bit [31:0] d0, d1; bit [3:0] b0, b1;
    bit [1:0] egnt, ervld; bit [31:0] er0, er1;
  } vec_t;

  function automatic vec_t mk(bit r, bit [1:0] rq, w, rd, bit [9:0] a0, a1, bit [31:0] d0, d1,
                              bit [3:0] b0, b1, bit [1:0] eg, ev, bit [31:0] e0, e1);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.rdy = rd; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.b0 = b0; v.b1 = b1; v.egnt = eg; v.ervld = ev; v.er0 = e0; v.er1 = e1;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < NW; i++) mdl_mem[i] = init_word(i);
    for (int m = 0; m < NM; m++) begin slot_v[m] = 0; slot_fresh[m] = 0; slot_d[m] = '0; end
    rr_next = 0;
    last_gnt = '0;
    set_in(1, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);

    // reset, write/read round trip with byte enables, two-master contention
    for (int i = 0; i < 3; i++) tbl[i] = mk(1, 2'b11, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    tbl[3]  = mk(0, 2'b11, 2'b01, 2'b11, 10'h010, 10'h020, 32'hDEADBEEF, 0, 4'hF, 0, 2'b01, 2'b00, 0, 0);
    tbl[4]  = mk(0, 2'b11, 2'b00, 2'b11, 10'h010, 10'h020, 0, 0, 4'hF, 0, 2'b10, 2'b01, 0, 0);
    tbl[5]  = mk(0, 2'b01, 2'b00, 2'b11, 10'h010, 10'h020, 0, 0, 4'hF, 0, 2'b01, 2'b10, 0, 32'h220);
    tbl[6]  = mk(0, 2'b01, 2'b01, 2'b11, 10'h010, 0, 32'h0000CAFE, 0, 4'h3, 0, 2'b01, 2'b01, 32'hDEADBEEF, 0);
    tbl[7]  = mk(0, 2'b01, 2'b00, 2'b11, 10'h010, 0, 0, 0, 4'hF, 0, 2'b01, 2'b01, 0, 0);
    tbl[8]  = mk(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'hDEADCAFE, 0);
    tbl[9]  = mk(0, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0, 4'hF, 4'hF, 2'b10, 2'b00, 0, 0);
    tbl[10] = mk(0, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0, 4'hF, 4'hF, 2'b01, 2'b10, 0, 32'h22);
    tbl[11] = mk(0, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0, 4'hF, 4'hF, 2'b10, 2'b01, 32'h11, 0);
    tbl[12] = mk(0, 2'b11, 2'b00, 2'b11, 1, 2, 0, 0, 4'hF, 4'hF, 2'b01, 2'b10, 0, 32'h22);
    tbl[13] = mk(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'h11, 0);
    tbl[14] = mk(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    next_edge();
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].rdy, tbl[i].a0, tbl[i].a1,
             tbl[i].d0, tbl[i].d1, tbl[i].b0, tbl[i].b1);
      settle_check();
      chk($sformatf("tbl%0d.gnt", i), 64'(gnt), 64'(tbl[i].egnt));
      chk($sformatf("tbl%0d.sram_req", i), 64'(sram_req), 64'(|tbl[i].egnt));
      chk($sformatf("tbl%0d.rvalid", i), 64'(rvalid), 64'(tbl[i].ervld));
      chk($sformatf("tbl%0d.rdata0", i), 64'(rdata[31:0]), 64'(tbl[i].er0));
      chk($sformatf("tbl%0d.rdata1", i), 64'(rdata[63:32]), 64'(tbl[i].er1));
      next_edge();
    end

    // backpressure: M1 stalls its read of addr 5 while M0 streams reads
    set_in(0, 2'b11, 2'b00, 2'b01, 8, 5, 0, 0, 4'hF, 4'hF);
    settle_check();
    chk("bp.first_gnt", 64'(gnt), 64'(2'b10));
    next_edge();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 2'b11, 2'b00, 2'b01, 10'(8 + i), 5, 0, 0, 4'hF, 4'hF);
      settle_check();
      chk($sformatf("bp%0d.gnt", i), 64'(gnt), 64'(2'b01));
      chk($sformatf("bp%0d.rvalid1", i), 64'(rvalid[1]), 64'(1'b1));
      chk($sformatf("bp%0d.rdata1", i), 64'(rdata[63:32]), 64'h55);
      next_edge();
    end
    set_in(0, 2'b11, 2'b00, 2'b11, 12, 5, 0, 0, 4'hF, 4'hF);
    settle_check();
    chk("bp.release_gnt", 64'(gnt), 64'(2'b01));
    chk("bp.release_rdata1", 64'(rdata[63:32]), 64'h55);
    next_edge();
    set_in(0, 2'b11, 2'b00, 2'b11, 13, 5, 0, 0, 4'hF, 4'hF);
    settle_check();
    chk("bp.regrant", 64'(gnt), 64'(2'b10));
    next_edge();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
      settle_check();
      next_edge();
    end

    // back-to-back reads from one master
    for (int k = 0; k < 9; k++) begin
      set_in(0, (k < 8) ? 2'b01 : 2'b00, 2'b00, 2'b11, 10'(k), 0, 0, 0, 4'hF, 0);
      settle_check();
      chk($sformatf("b2b%0d.gnt", k), 64'(gnt), 64'((k < 8) ? 2'b01 : 2'b00));
      if (k > 0) begin
        chk($sformatf("b2b%0d.rvalid0", k), 64'(rvalid[0]), 64'(1'b1));
        chk($sformatf("b2b%0d.rdata0", k), 64'(rdata[31:0]), 64'(init_word(k - 1)));
      end
      next_edge();
    end

    // reset while M1 holds a response and M0 is pending
    set_in(0, 2'b10, 2'b00, 2'b01, 0, 3, 0, 0, 0, 4'hF);
    settle_check();
    chk("rst_mid.gnt1", 64'(gnt), 64'(2'b10));
    next_edge();
    set_in(0, 2'b01, 2'b00, 2'b01, 4, 0, 0, 0, 4'hF, 0);
    settle_check();
    chk("rst_mid.gnt0", 64'(gnt), 64'(2'b01));
    chk("rst_mid.rvalid_pre", 64'(rvalid), 64'(2'b10));
    next_edge();
    set_in(1, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
    settle_check();
    chk("rst_mid.rvalid_in_rst", 64'(rvalid), 64'(2'b00));
    next_edge();
    set_in(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    settle_check();
    chk("rst_mid.rvalid_after", 64'(rvalid), 64'(2'b00));
    next_edge();
    set_in(0, 2'b01, 2'b00, 2'b11, 3, 0, 0, 0, 4'hF, 0);
    settle_check();
    chk("rst_mid.gnt_after", 64'(gnt), 64'(2'b01));
    next_edge();
    set_in(0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
    settle_check();
    chk("rst_mid.resp", 64'(rdata[31:0]), 64'h33);
    chk("rst_mid.rvalid_resp", 64'(rvalid), 64'(2'b01));
    next_edge();

    // random traffic; an ungranted request keeps its attributes stable
    for (int c = 0; c < 500; c++) begin
      for (int m = 0; m < NM; m++) begin
        if (!(req[m] && !last_gnt[m])) begin
          req[m] = ($urandom % 4) != 0;
          we[m] = $urandom % 2;
          addr[m*AW +: AW] = 10'($urandom % 16);
          wdata[m*DW +: DW] = $urandom;
          be[m*BW +: BW] = 4'($urandom % 16);
        end
        rready[m] = ($urandom % 4) != 0;
      end
      rst = ($urandom % 64) == 0;
      settle_check();
      next_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
